// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared parameters, opcodes and pack types for the fetch stage
package fetch_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int FETCH_WIDTH = 4;
  localparam int GSHARE_GLOBAL_HISTORY_WIDTH = 8;
  localparam int LOCAL_BHT_WIDTH = 8;
  localparam int CHECKPOINT_ID_WIDTH = 4;
  localparam int EXCEPTION_ID_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] INIT_PC = 32'h8000_0000;

  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [EXCEPTION_ID_WIDTH-1:0] EXC_INSTR_MISALIGNED = '0;

  typedef struct packed {
    logic                                   enable;
    logic [INSTRUCTION_WIDTH-1:0]           value;
    logic [ADDR_WIDTH-1:0]                  pc;
    logic                                   has_exception;
    logic [EXCEPTION_ID_WIDTH-1:0]          exception_id;
    logic [ADDR_WIDTH-1:0]                  exception_value;
    logic                                   predicted;
    logic                                   predicted_jump;
    logic [ADDR_WIDTH-1:0]                  predicted_next_pc;
    logic                                   checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0]         checkpoint_id;
  } fetch_decode_pack_t;

  typedef struct packed {
    logic [GSHARE_GLOBAL_HISTORY_WIDTH-1:0] global_history;
    logic [LOCAL_BHT_WIDTH-1:0]             local_history;
  } checkpoint_t;

  typedef struct packed {
    logic idle;
  } decode_feedback_pack_t;

  typedef struct packed {
    logic idle;
  } rename_feedback_pack_t;

  typedef struct packed {
    logic                  enable;
    logic                  flush;
    logic                  has_exception;
    logic [ADDR_WIDTH-1:0] exception_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  jump_enable;
    logic                  jump;
  } commit_feedback_pack_t;
endpackage

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - opcode classifier for control-flow and fence instructions
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       is_branch_o,
  output logic       is_fence_o
);
  assign is_branch_o = (opcode_i == OPCODE_BRANCH) || (opcode_i == OPCODE_JAL) ||
                       (opcode_i == OPCODE_JALR);
  assign is_fence_o  = (opcode_i == OPCODE_MISC_MEM);
endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - fetch stage: bus read, slot scan, branch prediction hookup, redirect
module fetch
  import fetch_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  output logic [ADDR_WIDTH-1:0]                  fetch_bus_addr_o,
  output logic                                   fetch_bus_read_req_o,
  input  logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0] bus_fetch_data_i,
  input  logic                                   bus_fetch_read_ack_i,
  output logic [ADDR_WIDTH-1:0]                  fetch_bp_pc_o,
  output logic [INSTRUCTION_WIDTH-1:0]           fetch_bp_instruction_o,
  output logic                                   fetch_bp_valid_o,
  input  logic                                   bp_fetch_jump_i,
  input  logic [ADDR_WIDTH-1:0]                  bp_fetch_next_pc_i,
  input  logic                                   bp_fetch_valid_i,
  input  logic [GSHARE_GLOBAL_HISTORY_WIDTH-1:0] bp_fetch_global_history_i,
  input  logic [LOCAL_BHT_WIDTH-1:0]             bp_fetch_local_history_i,
  output logic [ADDR_WIDTH-1:0]                  fetch_bp_update_pc_o,
  output logic [INSTRUCTION_WIDTH-1:0]           fetch_bp_update_instruction_o,
  output logic                                   fetch_bp_update_jump_o,
  output logic [ADDR_WIDTH-1:0]                  fetch_bp_update_next_pc_o,
  output logic                                   fetch_bp_update_valid_o,
  input  logic [CHECKPOINT_ID_WIDTH-1:0]         cpbuf_fetch_new_id_i,
  input  logic                                   cpbuf_fetch_new_id_valid_i,
  output checkpoint_t                            fetch_cpbuf_data_o,
  output logic                                   fetch_cpbuf_push_o,
  input  logic                                   stbuf_all_empty_i,
  input  decode_feedback_pack_t                  decode_feedback_pack_i,
  input  rename_feedback_pack_t                  rename_feedback_pack_i,
  input  commit_feedback_pack_t                  commit_feedback_pack_i,
  input  logic [FETCH_WIDTH-1:0]                 fetch_decode_fifo_data_in_enable_i,
  output fetch_decode_pack_t                     fetch_decode_fifo_data_in_o [0:FETCH_WIDTH-1],
  output logic [FETCH_WIDTH-1:0]                 fetch_decode_fifo_data_in_valid_o,
  output logic                                   fetch_decode_fifo_push_o,
  output logic                                   fetch_decode_fifo_flush_o,
  output logic                                   fetch_csrf_checkpoint_buffer_full_add_o,
  output logic                                   fetch_csrf_fetch_not_full_add_o,
  output logic                                   fetch_csrf_fetch_decode_fifo_full_add_o
);
  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic                         jump_wait_q, jump_wait_d;
  logic [ADDR_WIDTH-1:0]        wait_pc_q, wait_pc_d;
  logic [INSTRUCTION_WIDTH-1:0] wait_instruction_q, wait_instruction_d;

  logic [FETCH_WIDTH-1:0]       is_branch, is_fence;
  logic                         stop, redirect, fence_ok;
  logic [2:0]                   emitted;
  logic [ADDR_WIDTH-1:0]        slot_pc, redirect_pc;
  logic [INSTRUCTION_WIDTH-1:0] slot_instr;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_predecode
    fetch_predecode u_predecode (
      .opcode_i    (bus_fetch_data_i[INSTRUCTION_WIDTH*g +: 7]),
      .is_branch_o (is_branch[g]),
      .is_fence_o  (is_fence[g])
    );
  end

  assign fetch_bus_addr_o     = pc_q;
  assign fetch_bus_read_req_o = !jump_wait_q;
  assign fetch_cpbuf_data_o.global_history = bp_fetch_global_history_i;
  assign fetch_cpbuf_data_o.local_history  = bp_fetch_local_history_i;
  assign fence_ok = stbuf_all_empty_i && decode_feedback_pack_i.idle && rename_feedback_pack_i.idle;

  always_comb begin
    pc_d               = pc_q;
    jump_wait_d        = jump_wait_q;
    wait_pc_d          = wait_pc_q;
    wait_instruction_d = wait_instruction_q;
    fetch_bp_pc_o                 = '0;
    fetch_bp_instruction_o        = '0;
    fetch_bp_valid_o              = 1'b0;
    fetch_bp_update_pc_o          = '0;
    fetch_bp_update_instruction_o = '0;
    fetch_bp_update_jump_o        = 1'b0;
    fetch_bp_update_next_pc_o     = '0;
    fetch_bp_update_valid_o       = 1'b0;
    fetch_cpbuf_push_o            = 1'b0;
    fetch_decode_fifo_data_in_valid_o       = '0;
    fetch_decode_fifo_flush_o               = 1'b0;
    fetch_csrf_checkpoint_buffer_full_add_o = 1'b0;
    fetch_csrf_fetch_decode_fifo_full_add_o = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) fetch_decode_fifo_data_in_o[i] = '0;
    stop        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    emitted     = '0;
    slot_pc     = '0;
    slot_instr  = '0;

    if (commit_feedback_pack_i.enable && commit_feedback_pack_i.flush) begin
      fetch_decode_fifo_flush_o = 1'b1;
      pc_d = commit_feedback_pack_i.has_exception ? commit_feedback_pack_i.exception_pc
                                                  : commit_feedback_pack_i.next_pc;
      jump_wait_d = 1'b0;
    end else if (jump_wait_q) begin
      if (commit_feedback_pack_i.enable && commit_feedback_pack_i.jump_enable) begin
        pc_d = commit_feedback_pack_i.jump ? commit_feedback_pack_i.next_pc : wait_pc_q + 32'd4;
        jump_wait_d = 1'b0;
        fetch_bp_update_valid_o       = 1'b1;
        fetch_bp_update_pc_o          = wait_pc_q;
        fetch_bp_update_instruction_o = wait_instruction_q;
        fetch_bp_update_jump_o        = commit_feedback_pack_i.jump;
        fetch_bp_update_next_pc_o     = commit_feedback_pack_i.next_pc;
      end
    end else if (bus_fetch_read_ack_i) begin
      fetch_csrf_fetch_decode_fifo_full_add_o = (fetch_decode_fifo_data_in_enable_i == '0);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        slot_pc    = pc_q + ADDR_WIDTH'(4 * i);
        slot_instr = bus_fetch_data_i[INSTRUCTION_WIDTH*i +: INSTRUCTION_WIDTH];
        if (stop || !fetch_decode_fifo_data_in_enable_i[i]) begin
          stop = 1'b1;
        end else if (pc_q[1:0] != 2'b00) begin
          // Misaligned fetch: report once on slot 0 and park until commit redirects.
          fetch_decode_fifo_data_in_o[i].enable          = 1'b1;
          fetch_decode_fifo_data_in_o[i].value           = slot_instr;
          fetch_decode_fifo_data_in_o[i].pc              = slot_pc;
          fetch_decode_fifo_data_in_o[i].has_exception   = 1'b1;
          fetch_decode_fifo_data_in_o[i].exception_id    = EXC_INSTR_MISALIGNED;
          fetch_decode_fifo_data_in_o[i].exception_value = pc_q;
          fetch_decode_fifo_data_in_valid_o[i] = 1'b1;
          emitted     = emitted + 3'd1;
          jump_wait_d = 1'b1;
          stop        = 1'b1;
        end else if (is_branch[i]) begin
          stop = 1'b1;
          if (!cpbuf_fetch_new_id_valid_i) begin
            fetch_csrf_checkpoint_buffer_full_add_o = 1'b1;
          end else begin
            fetch_bp_valid_o       = 1'b1;
            fetch_bp_pc_o          = slot_pc;
            fetch_bp_instruction_o = slot_instr;
            fetch_cpbuf_push_o     = 1'b1;
            fetch_decode_fifo_data_in_o[i].enable              = 1'b1;
            fetch_decode_fifo_data_in_o[i].value               = slot_instr;
            fetch_decode_fifo_data_in_o[i].pc                  = slot_pc;
            fetch_decode_fifo_data_in_o[i].checkpoint_id_valid = 1'b1;
            fetch_decode_fifo_data_in_o[i].checkpoint_id       = cpbuf_fetch_new_id_i;
            fetch_decode_fifo_data_in_valid_o[i] = 1'b1;
            emitted = emitted + 3'd1;
            if (bp_fetch_valid_i) begin
              fetch_decode_fifo_data_in_o[i].predicted         = 1'b1;
              fetch_decode_fifo_data_in_o[i].predicted_jump    = bp_fetch_jump_i;
              fetch_decode_fifo_data_in_o[i].predicted_next_pc = bp_fetch_next_pc_i;
              redirect    = 1'b1;
              redirect_pc = bp_fetch_jump_i ? bp_fetch_next_pc_i : slot_pc + 32'd4;
            end else begin
              jump_wait_d        = 1'b1;
              wait_pc_d          = slot_pc;
              wait_instruction_d = slot_instr;
            end
          end
        end else if (is_fence[i] && !fence_ok) begin
          stop = 1'b1;
        end else begin
          fetch_decode_fifo_data_in_o[i].enable = 1'b1;
          fetch_decode_fifo_data_in_o[i].value  = slot_instr;
          fetch_decode_fifo_data_in_o[i].pc     = slot_pc;
          fetch_decode_fifo_data_in_valid_o[i]  = 1'b1;
          emitted = emitted + 3'd1;
        end
      end
      if (redirect) pc_d = redirect_pc;
      else if (!jump_wait_d) pc_d = pc_q + ADDR_WIDTH'({emitted, 2'b00});
    end
  end

  assign fetch_decode_fifo_push_o        = |fetch_decode_fifo_data_in_valid_o;
  assign fetch_csrf_fetch_not_full_add_o = (emitted != 3'd0) && (emitted < 3'(FETCH_WIDTH));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q               <= INIT_PC;
      jump_wait_q        <= 1'b0;
      wait_pc_q          <= '0;
      wait_instruction_q <= '0;
    end else begin
      pc_q               <= pc_d;
      jump_wait_q        <= jump_wait_d;
      wait_pc_q          <= wait_pc_d;
      wait_instruction_q <= wait_instruction_d;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for the fetch stage
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] ALU   = 32'h0000_0013;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] FENCE = 32'h0000_000F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic read_req;
  logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0] bus_data;
  logic bus_ack;
  logic [ADDR_WIDTH-1:0] bp_pc;
  logic [INSTRUCTION_WIDTH-1:0] bp_instr;
  logic bp_req_valid;
  logic bp_jump;
  logic [ADDR_WIDTH-1:0] bp_next_pc;
  logic bp_valid;
  logic [GSHARE_GLOBAL_HISTORY_WIDTH-1:0] bp_ghist;
  logic [LOCAL_BHT_WIDTH-1:0] bp_lhist;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic [INSTRUCTION_WIDTH-1:0] upd_instr;
  logic upd_jump;
  logic [ADDR_WIDTH-1:0] upd_next_pc;
  logic upd_valid;
  logic [CHECKPOINT_ID_WIDTH-1:0] new_id;
  logic new_id_valid;
  checkpoint_t cp_data;
  logic cp_push;
  logic stbuf_empty;
  decode_feedback_pack_t dfb;
  rename_feedback_pack_t rfb;
  commit_feedback_pack_t cfb;
  logic [FETCH_WIDTH-1:0] fifo_en;
  fetch_decode_pack_t fifo_data [0:FETCH_WIDTH-1];
  logic [FETCH_WIDTH-1:0] fifo_valid;
  logic fifo_push, fifo_flush, cp_full_add, not_full_add, fifo_full_add;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_bus_addr_o(bus_addr), .fetch_bus_read_req_o(read_req),
    .bus_fetch_data_i(bus_data), .bus_fetch_read_ack_i(bus_ack),
    .fetch_bp_pc_o(bp_pc), .fetch_bp_instruction_o(bp_instr), .fetch_bp_valid_o(bp_req_valid),
    .bp_fetch_jump_i(bp_jump), .bp_fetch_next_pc_i(bp_next_pc), .bp_fetch_valid_i(bp_valid),
    .bp_fetch_global_history_i(bp_ghist), .bp_fetch_local_history_i(bp_lhist),
    .fetch_bp_update_pc_o(upd_pc), .fetch_bp_update_instruction_o(upd_instr),
    .fetch_bp_update_jump_o(upd_jump), .fetch_bp_update_next_pc_o(upd_next_pc),
    .fetch_bp_update_valid_o(upd_valid),
    .cpbuf_fetch_new_id_i(new_id), .cpbuf_fetch_new_id_valid_i(new_id_valid),
    .fetch_cpbuf_data_o(cp_data), .fetch_cpbuf_push_o(cp_push),
    .stbuf_all_empty_i(stbuf_empty), .decode_feedback_pack_i(dfb),
    .rename_feedback_pack_i(rfb), .commit_feedback_pack_i(cfb),
    .fetch_decode_fifo_data_in_enable_i(fifo_en), .fetch_decode_fifo_data_in_o(fifo_data),
    .fetch_decode_fifo_data_in_valid_o(fifo_valid), .fetch_decode_fifo_push_o(fifo_push),
    .fetch_decode_fifo_flush_o(fifo_flush),
    .fetch_csrf_checkpoint_buffer_full_add_o(cp_full_add),
    .fetch_csrf_fetch_not_full_add_o(not_full_add),
    .fetch_csrf_fetch_decode_fifo_full_add_o(fifo_full_add)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_data = '0; bus_ack = 1'b0;
    bp_jump = 1'b0; bp_next_pc = '0; bp_valid = 1'b0; bp_ghist = '0; bp_lhist = '0;
    new_id = '0; new_id_valid = 1'b1; stbuf_empty = 1'b1;
    dfb = '{idle: 1'b1}; rfb = '{idle: 1'b1}; cfb = '0; fifo_en = 4'hF;
  endtask

  // Drive at the falling edge, check combinational outputs 1ns later.
  task automatic drive_start();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic clock_in();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_addr", bus_addr, 32'h8000_0000);
    chk("reset_read_req", read_req, 1);
    chk("reset_outputs_idle", {fifo_valid, fifo_push, fifo_flush, cp_push, upd_valid, bp_req_valid}, 0);

    // Four ALU ops at INIT_PC, all slots free.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, ALU, ALU};
    bp_ghist = 8'hA5; bp_lhist = 8'h3C;
    #1;
    chk("alu_valid", fifo_valid, 4'hF);
    chk("alu_push", fifo_push, 1);
    chk("alu_slot3_pc", fifo_data[3].pc, 32'h8000_000C);
    chk("alu_not_full", not_full_add, 0);
    chk("cp_hist", cp_data, 16'hA53C);
    clock_in();
    chk("alu_next_pc", bus_addr, 32'h8000_0010);

    // Slot 1 branch predicted taken to 0x80000100.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, BEQ, ALU};
    new_id = 4'd5; bp_valid = 1'b1; bp_jump = 1'b1; bp_next_pc = 32'h8000_0100;
    #1;
    chk("br_valid", fifo_valid, 4'h3);
    chk("br_cp_push", cp_push, 1);
    chk("br_bp_req", {bp_req_valid, bp_pc}, {1'b1, 32'h8000_0014});
    chk("br_ckpt", {fifo_data[1].checkpoint_id_valid, fifo_data[1].checkpoint_id}, {1'b1, 4'd5});
    chk("br_pred", {fifo_data[1].predicted, fifo_data[1].predicted_jump,
                    fifo_data[1].predicted_next_pc}, {2'b11, 32'h8000_0100});
    chk("br_not_full", not_full_add, 1);
    clock_in();
    chk("br_next_pc", bus_addr, 32'h8000_0100);

    // Slot 0 branch with no prediction: wait for commit to resolve.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, ALU, BEQ}; fifo_en = 4'h1;
    #1;
    chk("wait_valid", fifo_valid, 4'h1);
    chk("wait_cp_push", cp_push, 1);
    chk("wait_unpredicted", fifo_data[0].predicted, 0);
    clock_in();
    chk("wait_read_req", read_req, 0);
    drive_start();
    cfb.enable = 1'b1; cfb.jump_enable = 1'b1; cfb.jump = 1'b1; cfb.next_pc = 32'h8000_0200;
    #1;
    chk("upd_valid", upd_valid, 1);
    chk("upd_fields", {upd_pc, upd_instr, upd_jump, upd_next_pc},
        {32'h8000_0100, BEQ, 1'b1, 32'h8000_0200});
    clock_in();
    chk("resolve_pc", bus_addr, 32'h8000_0200);
    chk("resolve_read_req", read_req, 1);

    // Commit flush with exception outranks a simultaneous ack.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, ALU, ALU};
    cfb.enable = 1'b1; cfb.flush = 1'b1; cfb.has_exception = 1'b1;
    cfb.exception_pc = 32'h8000_0400; cfb.next_pc = 32'h8000_0800;
    #1;
    chk("flush_flag", fifo_flush, 1);
    chk("flush_no_push", {fifo_push, fifo_valid, cp_push}, 0);
    clock_in();
    chk("flush_pc", bus_addr, 32'h8000_0400);

    // Branch without a free checkpoint ends the group before it.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, BEQ, ALU}; new_id_valid = 1'b0;
    #1;
    chk("cpfull_add", cp_full_add, 1);
    chk("cpfull_valid", fifo_valid, 4'h1);
    chk("cpfull_no_cp_push", cp_push, 0);
    clock_in();
    chk("cpfull_pc", bus_addr, 32'h8000_0404);

    // No free FIFO slots.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, ALU, ALU}; fifo_en = 4'h0;
    #1;
    chk("full_add", fifo_full_add, 1);
    chk("full_no_push", fifo_push, 0);
    clock_in();
    chk("full_pc_held", bus_addr, 32'h8000_0404);

    // Fence blocked while the store buffer is busy, then accepted.
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, FENCE, ALU}; stbuf_empty = 1'b0;
    #1;
    chk("fence_blocked", fifo_valid, 4'h1);
    clock_in();
    chk("fence_blocked_pc", bus_addr, 32'h8000_0408);
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, FENCE, ALU};
    #1;
    chk("fence_ok", fifo_valid, 4'hF);
    clock_in();
    chk("fence_ok_pc", bus_addr, 32'h8000_0418);

    // No ack: outputs stay idle and pc holds.
    drive_start();
    #1;
    chk("noack_idle", {fifo_valid, fifo_push, cp_push, bp_req_valid, fifo_full_add}, 0);
    clock_in();
    chk("noack_pc", bus_addr, 32'h8000_0418);

    // Flush to a misaligned target, then fetch raises a slot-0 exception.
    drive_start();
    cfb.enable = 1'b1; cfb.flush = 1'b1; cfb.has_exception = 1'b1; cfb.exception_pc = 32'h8000_0502;
    clock_in();
    drive_start();
    bus_ack = 1'b1; bus_data = {ALU, ALU, ALU, ALU};
    #1;
    chk("misalign_valid", fifo_valid, 4'h1);
    chk("misalign_exc", {fifo_data[0].has_exception, fifo_data[0].exception_id,
                         fifo_data[0].exception_value}, {1'b1, 5'd0, 32'h8000_0502});
    clock_in();
    chk("misalign_wait", {read_req, bus_addr}, {1'b0, 32'h8000_0502});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Params from config: ADDR_WIDTH=32, INSTRUCTION_WIDTH=32, FETCH_WIDTH=4, GSHARE_GLOBAL_HISTORY_WIDTH, LOCAL_BHT_WIDTH, CHECKPOINT_ID_WIDTH, INIT_PC=0x80000000.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk in 1: clock; rst in 1: synchronous active-low reset.
REQ-004 fetch_bus_addr out ADDR: fetch address; fetch_bus_read_req out 1: read request; bus_fetch_data in 32*FETCH_WIDTH: slot i at bits [32i+:32]; bus_fetch_read_ack in 1: data valid this cycle.
REQ-005 fetch_bp_pc/fetch_bp_instruction/fetch_bp_valid out: predict request; bp_fetch_jump, bp_fetch_next_pc, bp_fetch_valid, bp_fetch_global_history, bp_fetch_local_history in: same-cycle prediction.
REQ-006 fetch_bp_update_pc/instruction/jump/next_pc/valid out: predictor training.
REQ-007 cpbuf_fetch_new_id, cpbuf_fetch_new_id_valid in; fetch_cpbuf_data (checkpoint_t) out; fetch_cpbuf_push out.
REQ-008 stbuf_all_empty in; decode_feedback_pack, rename_feedback_pack, commit_feedback_pack in (packed structs).
REQ-009 fetch_decode_fifo_data_in_enable in FETCH_WIDTH: free-slot mask; fetch_decode_fifo_data_in[0:FETCH_WIDTH-1] out; fetch_decode_fifo_data_in_valid out FETCH_WIDTH; fetch_decode_fifo_push, fetch_decode_fifo_flush out.
REQ-010 fetch_csrf_checkpoint_buffer_full_add, fetch_csrf_fetch_not_full_add, fetch_csrf_fetch_decode_fifo_full_add out 1: perf pulses.

Function
REQ-011 State: pc (ADDR), jump_wait (1), wait_pc, wait_instruction.
REQ-012 fetch_bus_read_req = !jump_wait; fetch_bus_addr = pc; both from registers only.
REQ-013 Flush (commit enable && flush) has top priority: fetch_decode_fifo_flush=1, no push, no cpbuf push; next pc = has_exception ? exception_pc : next_pc; jump_wait<=0.
REQ-014 While jump_wait and commit enable && jump_enable: pc <= jump ? next_pc : wait_pc+4; jump_wait<=0; fetch_bp_update_valid=1 with wait_pc, wait_instruction, jump, next_pc; else update_valid=0.
REQ-015 On ack and !jump_wait, slots i=0.. scanned in order at pc+4i, stopping at FETCH_WIDTH or first slot whose enable bit is 0.
REQ-016 pc[1:0]!=0: slot 0 emitted with has_exception=1, exception_id=0, exception_value=pc; jump_wait<=1; group ends.
REQ-017 Branch (opcode 1100011/1101111/1100111): at most one per group, driven on fetch_bp_*; needs cpbuf_fetch_new_id_valid, else group ends before it and checkpoint_buffer_full_add=1.
REQ-018 Accepted branch: checkpoint_id_valid=1, checkpoint_id=cpbuf_fetch_new_id, fetch_cpbuf_push=1; if bp_fetch_valid: predicted=1, predicted_jump/next_pc from BP, group ends, pc <= jump ? next_pc : addr+4; else predicted=0, jump_wait<=1, wait_pc/instruction latched.
REQ-019 fetch_cpbuf_data.global_history/local_history = bp_fetch_* histories combinationally at all times.
REQ-020 Fence (opcode 0001111) accepted only when stbuf_all_empty && decode idle && rename idle, else group ends before it.
REQ-021 Emitted entries: enable=1, value, pc; valid bit i set; push = |valid; otherwise pc <= pc+4*emitted.
REQ-022 fifo_full_add=1 on ack with enable mask 0; fetch_not_full_add=1 when 0<emitted<FETCH_WIDTH.
REQ-023 No ack: outputs idle, pc holds.

Reset
REQ-024 Reset: pc=INIT_PC, jump_wait=0, wait regs 0; all outputs 0 except bus_addr=INIT_PC, read_req=1 after release.

Structure
REQ-025 Shared package: fetch_decode_pack_t, checkpoint_t, decode/rename/commit_feedback_pack_t; constants in config header.
REQ-026 One sub-module: fetch_predecode (opcode -> is_branch, is_fence).

Verification
REQ-027 Reset release, ack, 4 ALU ops at 0x80000000, enable=0xF -> valid=0xF, push, pc=0x80000010.
REQ-028 Slot1 branch, bp_valid jump to 0x80000100 -> valid=0x3, cpbuf push, pc=0x80000100.
REQ-029 Slot0 branch, bp_valid=0 -> jump_wait=1, read_req=0; commit jump=1 next_pc=0x80000200 -> bp update, pc=0x80000200.
REQ-030 Commit flush with has_exception, exception_pc=0x80000400 -> fifo flush, no push, pc=0x80000400.
REQ-031 Branch with new_id_valid=0 -> checkpoint_buffer_full_add=1, branch not emitted; enable=0 -> fifo_full_add=1, pc held.
